max_pool_2x2_stream: RTL and testbench

- Streaming 2x2 / stride-2 max-pooling stage that sits directly downstream of block_2conv.
- Consumes the raster-ordered IEEE-754 single-precision feature-map stream that block_2conv produces, one channel plane after another.
- Emits the pooled plane (IMAGE_WIDTH/2 square) in raster order for the next convolution block.
- Uses a single half-width line buffer; no full-frame storage.

---
 rtl/vgg_pkg.sv | 26 ++
 rtl/pool_line_buffer.sv | 25 ++
 rtl/max_pool_2x2_stream.sv | 121 ++++++++++++
 tb/tb_max_pool_2x2_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vgg_pkg.sv
// Shared binary32 helpers for the VGG pooling/convolution chain: field
// constants, the +0 word and a sign-magnitude fmax.
package vgg_pkg;

  localparam int unsigned FP_WIDTH    = 32;
  localparam int unsigned FP_SIGN_POS = FP_WIDTH - 1;
  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_MAN_W    = 23;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = '0;

  // Sign-magnitude ordering on raw bits: positive beats negative (+0 > -0),
  // and an exact tie returns a.
  function automatic logic [FP_WIDTH-1:0] fmax(input logic [FP_WIDTH-1:0] a,
                                               input logic [FP_WIDTH-1:0] b);
    logic a_wins;
    if (a[FP_SIGN_POS] != b[FP_SIGN_POS])
      a_wins = ~a[FP_SIGN_POS];
    else if (!a[FP_SIGN_POS])
      a_wins = (a[FP_SIGN_POS-1:0] >= b[FP_SIGN_POS-1:0]);
    else
      a_wins = (a[FP_SIGN_POS-1:0] <= b[FP_SIGN_POS-1:0]);
    return a_wins ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Half-width line buffer: simple dual-port RAM, registered write,
// combinational read. Contents are not reset.
module pool_line_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 56,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2/stride-2 max pool over raster-ordered binary32 planes.
// Optional MAXPOOL_FUSED_RELU_EN forces negative (sign=1) results to +0.
module max_pool_2x2_stream
  import vgg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned IMAGE_WIDTH       = 112,
  parameter int unsigned NUMBER_OF_CHANNEL = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_busy
);

  localparam int unsigned HALF   = IMAGE_WIDTH / 2;
  localparam int unsigned POS_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned ADDR_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned CH_W   = (NUMBER_OF_CHANNEL > 1) ? $clog2(NUMBER_OF_CHANNEL) : 1;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(IMAGE_WIDTH - 1);
  localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(NUMBER_OF_CHANNEL - 1);

  generate
    if ((IMAGE_WIDTH % 2) != 0 || IMAGE_WIDTH < 2) begin : g_bad_width
      $error("max_pool_2x2_stream: IMAGE_WIDTH must be even and >= 2");
    end
    if (DATA_WIDTH != FP_WIDTH) begin : g_bad_data_width
      $error("max_pool_2x2_stream: DATA_WIDTH must match binary32");
    end
  endgenerate

  logic [POS_W-1:0]      col;
  logic [POS_W-1:0]      row;
  logic [CH_W-1:0]       ch;
  logic [DATA_WIDTH-1:0] hold;
  logic                  busy_r;

  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] lb_rdata;
  logic [DATA_WIDTH-1:0] pooled;
  logic [DATA_WIDTH-1:0] result;
  logic [ADDR_W-1:0]     lb_addr;
  logic                  col_end;
  logic                  row_end;
  logic                  map_end;
  logic                  lb_we;
  logic                  emit;

  always_comb begin
    col_end  = (col == POS_MAX);
    row_end  = (row == POS_MAX);
    map_end  = col_end && row_end && (ch == CH_MAX);
    lb_addr  = ADDR_W'(col >> 1);
    lb_we    = i_valid && col[0] && !row[0];
    emit     = i_valid && col[0] && row[0];
    pair_max = fmax(hold, i_data);
    pooled   = fmax(lb_rdata, pair_max);
`ifdef MAXPOOL_FUSED_RELU_EN
    result   = pooled[FP_SIGN_POS] ? FP_POS_ZERO : pooled;
`else
    result   = pooled;
`endif
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF),
    .ADDR_W     (ADDR_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      ch      <= '0;
      hold    <= '0;
      busy_r  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= emit;
      o_last  <= emit && map_end;
      if (emit)
        o_data <= result;
      if (i_valid) begin
        if (!col[0])
          hold <= i_data;
        busy_r <= !map_end;
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row <= '0;
            ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // A pixel accepted during the o_last cycle opens the next map, so busy
  // must not dip across a back-to-back boundary.
  assign o_busy = busy_r || (o_last && i_valid);

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Scoreboard bench for max_pool_2x2_stream on a 4x4x2 configuration.
module tb_max_pool_2x2_stream;

  localparam int W   = 4;
  localparam int NCH = 2;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_last;
  logic          o_busy;

  max_pool_2x2_stream #(
    .DATA_WIDTH        (DW),
    .IMAGE_WIDTH       (W),
    .NUMBER_OF_CHANNEL (NCH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int unsigned   at;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] outs[$];
  int            n_last = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] img[W][W];
  logic [DW-1:0] ramp[16];
  int            pr = 0, pc = 0, pch = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Map each word to an unsigned key whose natural order is the float order.
  function automatic logic [DW-1:0] order_key(input logic [DW-1:0] v);
    return v[DW-1] ? ~v : (v | 32'h8000_0000);
  endfunction

  function automatic logic [DW-1:0] ref_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (order_key(b) > order_key(a)) ? b : a;
  endfunction

  function automatic logic [DW-1:0] ref_out(input logic [DW-1:0] v);
`ifdef MAXPOOL_FUSED_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic drive_px(input logic [DW-1:0] v, input bit gaps);
    exp_t e;
    if (gaps) begin
      while ($urandom_range(99) < 30) begin
        @(posedge clk); #1 i_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = v;
    img[pr][pc] = v;
    if ((pr % 2 == 1) && (pc % 2 == 1)) begin
      e.data = ref_out(ref_max(ref_max(img[pr-1][pc-1], img[pr-1][pc]),
                               ref_max(img[pr][pc-1], img[pr][pc])));
      e.last = (pch == NCH - 1) && (pr == W - 1) && (pc == W - 1);
      e.at   = cyc + 1;
      sbq.push_back(e);
    end
    if (pc == W - 1) begin
      pc = 0;
      if (pr == W - 1) begin
        pr  = 0;
        pch = (pch == NCH - 1) ? 0 : pch + 1;
      end else pr++;
    end else pc++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1 i_valid = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] rand_word(input logic [DW-1:0] prev);
    logic [DW-1:0] v;
    v = $urandom;
    case ($urandom_range(3))
      0: v[30:0] = v[30:0] & 31'h0000_0003;
      1: v = prev;
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive_ramp_map();
    for (int p = 0; p < NCH; p++)
      for (int i = 0; i < 16; i++) drive_px(ramp[i], 1'b0);
  endtask

  task automatic drive_rand_map(input bit gaps);
    logic [DW-1:0] prev;
    prev = '0;
    for (int i = 0; i < W * W * NCH; i++) begin
      prev = rand_word(prev);
      drive_px(prev, gaps);
    end
  endtask

  task automatic check_ramp_outs(input string tag);
    check({tag, "_count"}, outs.size(), 8);
    if (outs.size() == 8) begin
      for (int p = 0; p < 2; p++) begin
        check({tag, "_o0"}, outs[4*p+0], 32'h40C0_0000);
        check({tag, "_o1"}, outs[4*p+1], 32'h4100_0000);
        check({tag, "_o2"}, outs[4*p+2], 32'h4160_0000);
        check({tag, "_o3"}, outs[4*p+3], 32'h4180_0000);
      end
    end
    check({tag, "_nlast"}, n_last, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_valid) begin
        if (sbq.size() == 0) check("unexpected_out", 1, 0);
        else begin
          e = sbq.pop_front();
          check("data", o_data, e.data);
          check("last", o_last, e.last);
          check("latency", cyc, e.at);
        end
        outs.push_back(o_data);
      end
      if (o_last) begin
        n_last++;
        check("last_valid", o_valid, 1);
        check("busy_at_last", o_busy, i_valid);
      end
    end
  end

  initial begin
    logic [DW-1:0] sign_plane[16];
    ramp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
             32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
             32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000,
             32'h4150_0000, 32'h4160_0000, 32'h4170_0000, 32'h4180_0000};
    sign_plane = '{32'hC040_0000, 32'hBF80_0000, 32'h8000_0000, 32'h0000_0000,
                   32'hC000_0000, 32'h8000_0000, 32'hC0A0_0000, 32'hC0E0_0000,
                   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};

    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_last", o_last, 0);
    check("rst_busy", o_busy, 0);
    #12 rst_n = 1'b1;
    idle(2);
    check("idle_busy", o_busy, 0);

    // Ramp 1.0..16.0 on both planes, continuous.
    outs.delete(); n_last = 0;
    for (int i = 0; i < 16; i++) drive_px(ramp[i], 1'b0);
    check("busy_mid", o_busy, 1);
    for (int i = 0; i < 16; i++) drive_px(ramp[i], 1'b0);
    idle(4);
    check_ramp_outs("ramp");
    check("ramp_busy_end", o_busy, 0);

    // Sign ordering and mixed zeros.
    outs.delete(); n_last = 0;
    for (int p = 0; p < NCH; p++)
      for (int i = 0; i < 16; i++) drive_px(sign_plane[i], 1'b0);
    idle(4);
    check("sign_count", outs.size(), 8);
    if (outs.size() == 8) begin
`ifdef MAXPOOL_FUSED_RELU_EN
      check("sign_neg0", outs[0], 32'h0000_0000);
`else
      check("sign_neg0", outs[0], 32'h8000_0000);
`endif
      check("mixed_zero", outs[1], 32'h0000_0000);
      check("sign_one", outs[2], 32'h3F80_0000);
    end

    // Back-to-back random maps.
    outs.delete(); n_last = 0;
    drive_rand_map(1'b0);
    drive_rand_map(1'b0);
    idle(4);
    check("b2b_count", outs.size(), 16);
    check("b2b_nlast", n_last, 2);
    check("b2b_busy_end", o_busy, 0);

    // Gapped random maps.
    outs.delete(); n_last = 0;
    for (int m = 0; m < 8; m++) drive_rand_map(1'b1);
    idle(4);
    check("gap_count", outs.size(), 64);
    check("gap_nlast", n_last, 8);

    // Asynchronous reset right after an output, mid second plane.
    for (int i = 0; i < 16; i++) drive_px(ramp[i], 1'b0);
    for (int i = 0; i < 8; i++) drive_px(ramp[i], 1'b0);
    @(posedge clk); #1;
    check("pre_rst_valid", o_valid, 1);
    #1 rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    check("mrst_valid", o_valid, 0);
    check("mrst_data", o_data, 0);
    check("mrst_busy", o_busy, 0);
    check("mrst_last", o_last, 0);
    sbq.delete();
    pr = 0; pc = 0; pch = 0;
    #20 rst_n = 1'b1;
    outs.delete(); n_last = 0;
    drive_ramp_map();
    idle(4);
    check_ramp_outs("post_rst");

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
